tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised melody player for the audio path; successor to the fixed single-tune beat/ROM/square-wave logic in the top level.
- Selects one of NUM_TRACKS tracks in a shared note ROM and steps through notes at a programmable beat rate.
- Generates a signed square-wave sample stream (with rests) and handshakes samples into the Audio_Controller output FIFO.
- Supports start/stop, looping, and pre-emption by a new request.

Parameters:
- NUM_TRACKS, 4: number of tracks; TRK_W = clog2(NUM_TRACKS), minimum 1.
- NOTE_W, 10: note-index width; each track has 2^NOTE_W ROM entries.
- HP_W, 19: width of a ROM entry, a half-period in clocks.
- BEAT_CYCLES, 2500000: clocks per note; minimum 2.
- AMPLITUDE, 100000000: peak sample magnitude; must be below 2^31.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- play_sel  in  TRK_W  track to start; sampled on play_req.
- play_req  in  1  one-cycle start pulse.
- stop  in  1  one-cycle stop pulse.
- loop_en  in  1  level; sampled at end-of-track.
- rom_addr  out  TRK_W+NOTE_W  {track, note_index} to the synchronous ROM.
- rom_q  in  HP_W  ROM data; valid exactly 1 cycle after rom_addr changes.
- audio_out_allowed  in  1  Audio_Controller output FIFO has space.
- sample_out  out  32  signed sample, applied to both channels.
- write_audio_out  out  1  write strobe to the Audio_Controller.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at natural end of track.

Behaviour:
- Reset (async, resetn=0) drives: state=IDLE, rom_addr=0, sample_out=0, write_audio_out=0, busy=0, done=0, square phase=0, and all counters 0.
- ROM entry encoding: 0 = rest, outputting silence for the whole beat. All-ones = end marker. Any other value = half-period H clocks.
- FSM states:
  - IDLE: on play_req, latch track=play_sel, set note_index=0, go to FETCH.
  - FETCH: drive rom_addr={track, note_index}, go to WAIT.
  - WAIT: one cycle for ROM latency. Then latch hp=rom_q.
    - If hp is the end marker: go to END.
    - Otherwise clear the beat and period counters, set phase=0, go to PLAY.
  - PLAY: the beat counter counts 0..BEAT_CYCLES-1.
    - The period counter counts 0..hp-1; on reaching hp-1 it returns to 0 and phase toggles. With hp=1, phase toggles every cycle.
    - When the beat counter reaches BEAT_CYCLES-1:
      - If note_index is the all-ones index, go to END, because the index does not wrap into the next track.
      - Otherwise increment note_index and go to FETCH.
  - END: if loop_en=1, set note_index=0 and go to FETCH, with no done pulse. Otherwise pulse done for 1 cycle and go to IDLE.
- Note-to-note gap is 2 cycles (FETCH and WAIT), during which sample_out holds 0.
- Sample value: in PLAY with hp≠0, sample_out = phase ? +AMPLITUDE : −AMPLITUDE, in two's complement, 32-bit. Otherwise sample_out = 0. The output is registered and follows phase with 1 cycle of latency.
- Handshake: write_audio_out = busy & audio_out_allowed, registered alongside sample_out.
  - Samples are offered whenever busy; none are issued while audio_out_allowed=0.
  - Backpressure does not stall timing; the note clock is free-running.
- Precedence each cycle: reset > stop > play_req > normal sequencing.
  - stop in any state: go to IDLE next cycle, sample_out=0, write_audio_out=0, no done pulse.
  - play_req while busy: pre-empt. Latch the new play_sel, note_index=0, go to FETCH. Any done pulse in progress is suppressed.
  - play_req and stop in the same cycle: stop wins, and the block ends in IDLE.
- End marker at index 0: the track ends after FETCH and WAIT, with no PLAY state. Done asserts 3 cycles after play_req (loop_en=0).
- loop_en is sampled only in END; changing it mid-note has no effect until the end of the track.
- Arithmetic: all counters are unsigned. Counter widths are clog2(BEAT_CYCLES) and HP_W; no overflow is possible.

Test Plan:
- Bench parameters: NUM_TRACKS=2, NOTE_W=2, BEAT_CYCLES=8, AMPLITUDE=1000, with a behavioural 1-cycle ROM model.
- Track 0 = {2, 0, 3, all-ones}; play_sel=0, play_req pulse, audio_out_allowed=1, loop_en=0.
  - Required: rom_addr steps 0,1,2,3.
  - Note 0 produces a ±1000 square wave toggling every 2 cycles for 8 cycles.
  - Note 1 produces 0 for 8 cycles.
  - Note 2 toggles every 3 cycles.
  - Then done pulses once, busy falls, and write_audio_out falls.
- Track 1 = {1, 1, 1, 1} with loop_en=1.
  - Required: rom_addr wraps from 7 to 4 with no done pulse, and the phase toggles every cycle.
  - Then deassert loop_en: done pulses after the index-3 note.
- Track 0 playing; play_req with play_sel=1 during note 1.
  - Required: FETCH of address 4 next cycle, sample_out=0 for 2 cycles, no done pulse.
- stop and play_req asserted in the same cycle while playing.
  - Required: IDLE next cycle, busy=0, sample_out=0, done=0.
- audio_out_allowed held at 0 for 5 cycles mid-note.
  - Required: write_audio_out=0 for those cycles.
  - The note still ends at its original cycle count, with beat timing unchanged.
- resetn asserted asynchronously between clock edges mid-PLAY.
  - Required: all outputs reach their reset values before the next edge.
  - After release, the block stays in IDLE until play_req.

Source files
------------

// File: rtl/tone_sequencer.sv
// Melody player: walks one track of a shared half-period ROM at a fixed beat rate
// and streams a signed square wave (with rests) into the audio output FIFO.
module tone_sequencer #(
    parameter int NUM_TRACKS  = 4,
    parameter int NOTE_W      = 10,
    parameter int HP_W        = 19,
    parameter int BEAT_CYCLES = 2500000,
    parameter int AMPLITUDE   = 100000000,
    localparam int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic [TRK_W-1:0]         play_sel,
    input  logic                     play_req,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [TRK_W+NOTE_W-1:0]  rom_addr,
    input  logic [HP_W-1:0]          rom_q,
    input  logic                     audio_out_allowed,
    output logic signed [31:0]       sample_out,
    output logic                     write_audio_out,
    output logic                     busy,
    output logic                     done
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic signed [31:0] AMP = 32'(AMPLITUDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_END
    } state_t;

    state_t                    state_q, state_d;
    logic [TRK_W-1:0]          track_q, track_d;
    logic [NOTE_W-1:0]         note_q, note_d, note_nxt;
    logic [HP_W-1:0]           hp_q, hp_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [HP_W-1:0]           per_q, per_d;
    logic                      phase_q, phase_d;
    logic [TRK_W+NOTE_W-1:0]   rom_addr_q, rom_addr_d;
    logic signed [31:0]        sample_q, sample_d;
    logic                      write_q, write_d;
    logic                      done_q, done_d;

    function automatic logic signed [31:0] tone_level(input logic ph);
        return ph ? AMP : -AMP;
    endfunction

    assign busy            = (state_q != S_IDLE);
    assign rom_addr        = rom_addr_q;
    assign sample_out      = sample_q;
    assign write_audio_out = write_q;
    assign done            = done_q;

    always_comb begin
        state_d    = state_q;
        track_d    = track_q;
        note_d     = note_q;
        hp_d       = hp_q;
        beat_d     = beat_q;
        per_d      = per_q;
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;
        done_d     = 1'b0;
        note_nxt   = note_q + 1'b1;
        sample_d   = (state_q == S_PLAY && hp_q != '0) ? tone_level(phase_q) : '0;
        write_d    = busy & audio_out_allowed;

        if (stop) begin
            state_d  = S_IDLE;
            sample_d = '0;
            write_d  = 1'b0;
        end else if (play_req) begin
            // New request restarts from note 0 regardless of current state
            track_d    = play_sel;
            note_d     = '0;
            rom_addr_d = {play_sel, {NOTE_W{1'b0}}};
            state_d    = S_FETCH;
            sample_d   = '0;
        end else begin
            case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    hp_d = rom_q;
                    if (rom_q == '1) begin
                        state_d = S_END;
                    end else begin
                        beat_d  = '0;
                        per_d   = '0;
                        phase_d = 1'b0;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    beat_d = beat_q + 1'b1;
                    if (hp_q != '0) begin
                        if (per_q == hp_q - 1'b1) begin
                            per_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            per_d = per_q + 1'b1;
                        end
                    end
                    if (beat_q == BEAT_LAST) begin
                        // Last index ends the track rather than spilling into the next one
                        if (note_q == '1) begin
                            state_d = S_END;
                        end else begin
                            note_d     = note_nxt;
                            rom_addr_d = {track_q, note_nxt};
                            state_d    = S_FETCH;
                        end
                    end
                end
                S_END: begin
                    if (loop_en) begin
                        note_d     = '0;
                        rom_addr_d = {track_q, {NOTE_W{1'b0}}};
                        state_d    = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            track_q    <= '0;
            note_q     <= '0;
            hp_q       <= '0;
            beat_q     <= '0;
            per_q      <= '0;
            phase_q    <= 1'b0;
            rom_addr_q <= '0;
            sample_q   <= '0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            track_q    <= track_d;
            note_q     <= note_d;
            hp_q       <= hp_d;
            beat_q     <= beat_d;
            per_q      <= per_d;
            phase_q    <= phase_d;
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            write_q    <= write_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: small two-track ROM, 8-cycle beats, amplitude 1000.
module tb_tone_sequencer;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [0:0]         play_sel = '0;
    logic               play_req = 1'b0;
    logic               stop = 1'b0;
    logic               loop_en = 1'b0;
    logic [2:0]         rom_addr;
    logic [18:0]        rom_q = '0;
    logic               audio_out_allowed = 1'b1;
    logic signed [31:0] sample_out;
    logic               write_audio_out;
    logic               busy;
    logic               done;

    int checks = 0;
    int failures = 0;

    logic [18:0] rom [8];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_q <= rom[rom_addr];

    tone_sequencer #(
        .NUM_TRACKS (2),
        .NOTE_W     (2),
        .HP_W       (19),
        .BEAT_CYCLES(8),
        .AMPLITUDE  (1000)
    ) dut (
        .CLOCK_50         (clk),
        .resetn           (resetn),
        .play_sel         (play_sel),
        .play_req         (play_req),
        .stop             (stop),
        .loop_en          (loop_en),
        .rom_addr         (rom_addr),
        .rom_q            (rom_q),
        .audio_out_allowed(audio_out_allowed),
        .sample_out       (sample_out),
        .write_audio_out  (write_audio_out),
        .busy             (busy),
        .done             (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [0:0] sel);
        play_sel = sel;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (sample_out !== 32'sd0 || write_audio_out !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || rom_addr !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: sample=%0d wr=%b busy=%b done=%b addr=%0d required 0/0/0/0/0",
                     sample_out, write_audio_out, busy, done, rom_addr);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_track0();
        int sg [35] = '{0, 0, 0, -1, -1, 1, 1, -1, -1, 1, 1,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                        -1, -1, -1, 1, 1, 1, -1, -1,
                        0, 0, 0, 0};
        logic signed [31:0] exp_s;
        logic [2:0] exp_a;
        logic exp_b, exp_d, exp_w;
        loop_en = 1'b0;
        play(1'b0);
        for (int k = 0; k < 35; k++) begin
            exp_s = sg[k] * 1000;
            exp_a = (k < 10) ? 3'd0 : (k < 20) ? 3'd1 : (k < 30) ? 3'd2 : 3'd3;
            exp_b = (k <= 32);
            exp_d = (k == 33);
            exp_w = (k >= 1 && k <= 33);
            checks++;
            if (sample_out !== exp_s) begin
                failures++;
                $display("FAIL track0_sample k=%0d: got %0d required %0d", k, sample_out, exp_s);
            end
            checks++;
            if (rom_addr !== exp_a) begin
                failures++;
                $display("FAIL track0_addr k=%0d: got %0d required %0d", k, rom_addr, exp_a);
            end
            checks++;
            if (busy !== exp_b || done !== exp_d || write_audio_out !== exp_w) begin
                failures++;
                $display("FAIL track0_ctrl k=%0d: busy=%b done=%b wr=%b required %b/%b/%b",
                         k, busy, done, write_audio_out, exp_b, exp_d, exp_w);
            end
            tick();
        end
    endtask

    task automatic test_loop();
        logic exp_d;
        loop_en = 1'b1;
        play(1'b1);
        for (int k = 0; k < 84; k++) begin
            if (k == 3 || k == 4 || k == 5) begin
                checks++;
                if (sample_out !== ((k == 4) ? 32'sd1000 : -32'sd1000)) begin
                    failures++;
                    $display("FAIL loop_hp1_sample k=%0d: got %0d", k, sample_out);
                end
            end
            if (k == 40) begin
                checks++;
                if (rom_addr !== 3'd7) begin
                    failures++;
                    $display("FAIL loop_last_addr: got %0d required 7", rom_addr);
                end
            end
            if (k == 41) begin
                checks++;
                if (rom_addr !== 3'd4 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL loop_wrap: addr=%0d busy=%b required 4/1", rom_addr, busy);
                end
                loop_en = 1'b0;
            end
            exp_d = (k == 82);
            checks++;
            if (done !== exp_d) begin
                failures++;
                $display("FAIL loop_done k=%0d: got %b required %b", k, done, exp_d);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL loop_end_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_preempt();
        play(1'b0);
        for (int k = 1; k <= 14; k++) tick();
        play_sel = 1'b1;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        checks++;
        if (rom_addr !== 3'd4 || sample_out !== 32'sd0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL preempt_fetch: addr=%0d sample=%0d busy=%b done=%b required 4/0/1/0",
                     rom_addr, sample_out, busy, done);
        end
        tick();
        checks++;
        if (sample_out !== 32'sd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL preempt_wait: sample=%0d done=%b required 0/0", sample_out, done);
        end
        tick();
        tick();
        checks++;
        if (sample_out !== -32'sd1000 || done !== 1'b0) begin
            failures++;
            $display("FAIL preempt_play: sample=%0d done=%b required -1000/0", sample_out, done);
        end
        tick();
        checks++;
        if (sample_out !== 32'sd1000) begin
            failures++;
            $display("FAIL preempt_play2: sample=%0d required 1000", sample_out);
        end
        do_stop();
    endtask

    task automatic test_stop_and_play();
        play(1'b0);
        for (int k = 1; k <= 5; k++) tick();
        checks++;
        if (sample_out !== 32'sd1000) begin
            failures++;
            $display("FAIL stop_pre_sample: got %0d required 1000", sample_out);
        end
        stop = 1'b1;
        play_req = 1'b1;
        play_sel = 1'b1;
        tick();
        stop = 1'b0;
        play_req = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_out !== 32'sd0 || done !== 1'b0 || write_audio_out !== 1'b0) begin
            failures++;
            $display("FAIL stop_wins: busy=%b sample=%0d done=%b wr=%b required 0/0/0/0",
                     busy, sample_out, done, write_audio_out);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || rom_addr !== 3'd0) begin
            failures++;
            $display("FAIL stop_stays_idle: busy=%b addr=%0d required 0/0", busy, rom_addr);
        end
    endtask

    task automatic test_backpressure();
        play(1'b0);
        for (int k = 1; k <= 4; k++) tick();
        audio_out_allowed = 1'b0;
        for (int k = 5; k <= 9; k++) begin
            tick();
            checks++;
            if (write_audio_out !== 1'b0) begin
                failures++;
                $display("FAIL bp_write k=%0d: got %b required 0", k, write_audio_out);
            end
        end
        checks++;
        if (sample_out !== 32'sd1000) begin
            failures++;
            $display("FAIL bp_sample: got %0d required 1000", sample_out);
        end
        audio_out_allowed = 1'b1;
        tick();
        checks++;
        if (write_audio_out !== 1'b1 || rom_addr !== 3'd1) begin
            failures++;
            $display("FAIL bp_note_end: wr=%b addr=%0d required 1/1", write_audio_out, rom_addr);
        end
        do_stop();
    endtask

    task automatic test_end_marker_first();
        rom[0] = 19'h7FFFF;
        play(1'b0);
        tick();
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL endmark_early: done=%b busy=%b required 0/1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL endmark_done: done=%b busy=%b required 1/0", done, busy);
        end
        rom[0] = 19'd2;
        tick();
    endtask

    task automatic test_async_reset();
        play(1'b0);
        for (int k = 1; k <= 5; k++) tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (sample_out !== 32'sd0 || write_audio_out !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || rom_addr !== 3'd0) begin
            failures++;
            $display("FAIL async_reset: sample=%0d wr=%b busy=%b done=%b addr=%0d required all 0",
                     sample_out, write_audio_out, busy, done, rom_addr);
        end
        #1;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || rom_addr !== 3'd0 || sample_out !== 32'sd0) begin
                failures++;
                $display("FAIL async_reset_idle c=%0d: busy=%b addr=%0d sample=%0d required 0/0/0",
                         k, busy, rom_addr, sample_out);
            end
        end
    endtask

    initial begin
        rom[0] = 19'd2;
        rom[1] = 19'd0;
        rom[2] = 19'd3;
        rom[3] = 19'h7FFFF;
        rom[4] = 19'd1;
        rom[5] = 19'd1;
        rom[6] = 19'd1;
        rom[7] = 19'd1;
        test_reset();
        test_track0();
        test_loop();
        test_preempt();
        test_stop_and_play();
        test_backpressure();
        test_end_marker_first();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
